id_ex_stage: RTL

- ID/EX pipeline register of the 5-stage RV32I core, directly upstream of the EX-stage ALU.
- Latches decoded operands and control from ID, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and drives alu_op / alu_in_1 / alu_in_2 into the ALU.
- Detects load-use hazards and requests an IF/ID stall; accepts a branch flush from EX.

---
 rtl/core_pkg.sv | 39 +++
 rtl/forwarding_unit.sv | 23 ++
 rtl/id_ex_stage.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared constants and types for the RV32I core pipeline.
// ALU op codes and forwarding selects used by the ID/EX stage.
package core_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_OR  = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0111;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    function automatic fwd_sel_e fwd_pick(
        input logic [REG_AW-1:0] src,
        input logic              exmem_we,
        input logic [REG_AW-1:0] exmem_rd,
        input logic              memwb_we,
        input logic [REG_AW-1:0] memwb_rd
    );
        // x0 is hardwired zero, so a write to it never forwards
        if (exmem_we && exmem_rd != '0 && exmem_rd == src)
            return FWD_EXMEM;
        else if (memwb_we && memwb_rd != '0 && memwb_rd == src)
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/forwarding_unit.sv
// RAW forwarding select for the two EX-stage source operands.
// EX/MEM wins over MEM/WB when both hold the same destination.
module forwarding_unit
    import core_pkg::*;
(
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    input  logic              i_exmem_we,
    input  logic [REG_AW-1:0] i_exmem_rd,
    input  logic              i_memwb_we,
    input  logic [REG_AW-1:0] i_memwb_rd,
    output fwd_sel_e          o_fwd1,
    output fwd_sel_e          o_fwd2
);

    always_comb begin
        o_fwd1 = fwd_pick(i_rs1, i_exmem_we, i_exmem_rd,
                          i_memwb_we, i_memwb_rd);
        o_fwd2 = fwd_pick(i_rs2, i_exmem_we, i_exmem_rd,
                          i_memwb_we, i_memwb_rd);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding, load-use stall and flush.
// Drives the EX-stage ALU operands and the EX/MEM control bundle.
module id_ex_stage
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [3:0]        id_alu_op,
    input  logic              id_alu_src_a_pc,
    input  logic              id_alu_src_b_imm,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_reg_write,
    input  logic              id_mem_to_reg,
    input  logic              flush,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [XLEN-1:0]   exmem_alu_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [XLEN-1:0]   memwb_wb_data,
    output logic              stall_if_id,
    output logic              ex_valid,
    output logic [3:0]        alu_op,
    output logic [XLEN-1:0]   alu_in_1,
    output logic [XLEN-1:0]   alu_in_2,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_reg_write,
    output logic              ex_mem_to_reg
);

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [XLEN-1:0]   r_imm;
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;
    logic [REG_AW-1:0] r_rd;
    logic [3:0]        r_alu_op;
    logic              r_src_a_pc;
    logic              r_src_b_imm;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_reg_write;
    logic              r_mem_to_reg;

    logic              w_load_use;
    logic              w_bubble;
    logic              w_take;
    fwd_sel_e          w_fwd1_sel;
    fwd_sel_e          w_fwd2_sel;
    logic [XLEN-1:0]   w_fwd1;
    logic [XLEN-1:0]   w_fwd2;

    // Both sources are checked even if the ID opcode ignores rs2
    assign w_load_use = r_valid && r_mem_read && (r_rd != '0) &&
                        id_valid &&
                        ((r_rd == id_rs1) || (r_rd == id_rs2));

    assign stall_if_id = w_load_use && !flush;
    assign w_bubble    = flush || w_load_use;
    assign w_take      = !w_bubble && id_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_imm        <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_alu_op     <= ALU_NOP;
            r_src_a_pc   <= 1'b0;
            r_src_b_imm  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else begin
            r_valid      <= w_take;
            r_pc         <= id_pc;
            r_rs1_data   <= id_rs1_data;
            r_rs2_data   <= id_rs2_data;
            r_imm        <= id_imm;
            r_rs1        <= id_rs1;
            r_rs2        <= id_rs2;
            r_rd         <= w_bubble ? '0 : id_rd;
            r_alu_op     <= w_take ? id_alu_op : ALU_NOP;
            r_src_a_pc   <= w_take && id_alu_src_a_pc;
            r_src_b_imm  <= w_take && id_alu_src_b_imm;
            r_mem_read   <= w_take && id_mem_read;
            r_mem_write  <= w_take && id_mem_write;
            r_reg_write  <= w_take && id_reg_write;
            r_mem_to_reg <= w_take && id_mem_to_reg;
        end
    end

    forwarding_unit u_fwd (
        .i_rs1      (r_rs1),
        .i_rs2      (r_rs2),
        .i_exmem_we (exmem_reg_write),
        .i_exmem_rd (exmem_rd),
        .i_memwb_we (memwb_reg_write),
        .i_memwb_rd (memwb_rd),
        .o_fwd1     (w_fwd1_sel),
        .o_fwd2     (w_fwd2_sel)
    );

    always_comb begin
        w_fwd1 = r_rs1_data;
        unique case (w_fwd1_sel)
            FWD_EXMEM: w_fwd1 = exmem_alu_result;
            FWD_MEMWB: w_fwd1 = memwb_wb_data;
            default:   w_fwd1 = r_rs1_data;
        endcase
    end

    always_comb begin
        w_fwd2 = r_rs2_data;
        unique case (w_fwd2_sel)
            FWD_EXMEM: w_fwd2 = exmem_alu_result;
            FWD_MEMWB: w_fwd2 = memwb_wb_data;
            default:   w_fwd2 = r_rs2_data;
        endcase
    end

    assign alu_in_1      = r_src_a_pc ? r_pc : w_fwd1;
    assign alu_in_2      = r_src_b_imm ? r_imm : w_fwd2;
    assign ex_store_data = w_fwd2;

    assign ex_valid      = r_valid;
    assign alu_op        = r_alu_op;
    assign ex_rd         = r_rd;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_to_reg = r_mem_to_reg;

endmodule
